// File: rtl/hilo_muldiv_pkg.sv
// Shared CPU definitions for the HI/LO multiply-divide unit.
package hilo_muldiv_pkg;

  localparam int CPU_XLEN = 32;
  localparam int DIV_ITER = CPU_XLEN;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/hilo_muldiv_div_iter_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder, trial-subtract the divisor, and emit one quotient bit.
module div_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0]   shifted_s;
  logic [DATA_W-1:0] diff_s;
  logic              fits_s;

  assign shifted_s = {rem_in, quo_in[DATA_W-1]};
  // Modular difference is exact whenever the divisor fits.
  assign diff_s    = shifted_s[DATA_W-1:0] - divisor;
  assign fits_s    = (shifted_s >= {1'b0, divisor});

  // Keep the difference and set the quotient bit only when the subtract succeeds.
  always_comb begin
    rem_out = shifted_s[DATA_W-1:0];
    quo_out = {quo_in[DATA_W-2:0], 1'b0};
    if (fits_s) begin
      rem_out = diff_s;
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end else begin
      rem_out = shifted_s[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: single-cycle MULT/MULTU and a radix-2
// restoring DIV/DIVU that iterates one quotient bit per cycle.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W = CPU_XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     src_a,
  input  logic [DATA_W-1:0]     src_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  hl_write_enable,
  output logic [2*DATA_W-1:0]   hl_data
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  state_e              state_r, next_state_s;
  op_e                 op_r;
  logic [DATA_W-1:0]   a_r, b_r, rem_r, quo_r, dvsr_r;
  logic                neg_quo_r, neg_rem_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                accept_s, load_hl_s, is_div_s;
  logic [2*DATA_W-1:0] hl_next_s, mul_a_s, mul_b_s, prod_s;
  logic [DATA_W-1:0]   step_rem_s, step_quo_s, quo_fin_s, rem_fin_s;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic sgn);
    return (sgn && v[DATA_W-1]) ? ({DATA_W{1'b0}} - v) : v;
  endfunction

  div_iter_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .divisor (dvsr_r),
    .rem_out (step_rem_s),
    .quo_out (step_quo_s)
  );

  // Sign-extend for MULT so a truncated unsigned product gives the signed result.
  assign mul_a_s   = {{DATA_W{(op_r == OP_MULT) & a_r[DATA_W-1]}}, a_r};
  assign mul_b_s   = {{DATA_W{(op_r == OP_MULT) & b_r[DATA_W-1]}}, b_r};
  assign prod_s    = mul_a_s * mul_b_s;
  assign quo_fin_s = neg_quo_r ? ({DATA_W{1'b0}} - step_quo_s) : step_quo_s;
  assign rem_fin_s = neg_rem_r ? ({DATA_W{1'b0}} - step_rem_s) : step_rem_s;
  assign is_div_s  = (op == OP_DIV);

  assign busy            = (state_r != IDLE);
  assign hl_write_enable = (state_r == DONE) & ~flush;

  // Next-state decode plus the HI/LO load decision on entry to DONE.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    load_hl_s    = 1'b0;
    hl_next_s    = hl_data;
    case (state_r)
      IDLE: begin
        if (start && !flush) begin
          accept_s     = 1'b1;
          next_state_s = op[1] ? DIV : MUL;
        end else begin
          next_state_s = IDLE;
        end
      end
      MUL: begin
        if (flush) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
          load_hl_s    = 1'b1;
          hl_next_s    = prod_s;
        end
      end
      DIV: begin
        if (flush) begin
          next_state_s = IDLE;
        end else if (b_r == {DATA_W{1'b0}}) begin
          next_state_s = DONE;
          load_hl_s    = 1'b1;
          hl_next_s    = {a_r, {DATA_W{1'b1}}};
        end else if (cnt_r == LAST_CNT) begin
          next_state_s = DONE;
          load_hl_s    = 1'b1;
          hl_next_s    = {rem_fin_s, quo_fin_s};
        end else begin
          next_state_s = DIV;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture, division iteration and the registered HI/LO result.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r      <= OP_MULT;
      a_r       <= {DATA_W{1'b0}};
      b_r       <= {DATA_W{1'b0}};
      rem_r     <= {DATA_W{1'b0}};
      quo_r     <= {DATA_W{1'b0}};
      dvsr_r    <= {DATA_W{1'b0}};
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      hl_data   <= {2*DATA_W{1'b0}};
    end else begin
      if (load_hl_s) begin
        hl_data <= hl_next_s;
      end
      if (accept_s) begin
        op_r      <= op_e'(op);
        a_r       <= src_a;
        b_r       <= src_b;
        rem_r     <= {DATA_W{1'b0}};
        quo_r     <= magnitude(src_a, is_div_s);
        dvsr_r    <= magnitude(src_b, is_div_s);
        neg_quo_r <= is_div_s & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
        neg_rem_r <= is_div_s & src_a[DATA_W-1];
        cnt_r     <= {CNT_W{1'b0}};
      end else if (state_r == DIV && !flush) begin
        rem_r <= step_rem_s;
        quo_r <= step_quo_s;
        if (cnt_r != LAST_CNT) begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv: multiply, divide, divide-by-zero,
// flush, ignored start, mid-operation reset and back-to-back issue.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, hl_write_enable;
  logic [63:0] hl_data;

  int tests = 0;
  int fails = 0;

  hilo_muldiv #(.DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .src_a           (src_a),
    .src_b           (src_b),
    .flush           (flush),
    .busy            (busy),
    .hl_write_enable (hl_write_enable),
    .hl_data         (hl_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue at cycle N, count cycles to the strobe, then check the post-DONE cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_hl);
    int lat;
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!hl_write_enable && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " hl_data"}, hl_data, exp_hl);
    tick();
    check({tag, " after done"}, {62'd0, hl_write_enable, busy}, 64'd0);
  endtask

  initial begin
    int strobes;
    int first_cyc;
    logic [63:0] first_hl;
    logic seen_we;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    tick();
    tick();
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset we", {63'd0, hl_write_enable}, 64'd0);
    check("reset hl", hl_data, 64'd0);
    rst = 1'b0;
    tick();

    run_op("mult -1x2", 2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 2, 64'h0000_0001_FFFF_FFFE);
    run_op("mult -3x-5", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 2, 64'h0000_0000_0000_000F);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 33, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu 7/2", 2'b11, 32'h0000_0007, 32'h0000_0002, 33, 64'h0000_0001_0000_0003);
    run_op("div 7/-2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 33, 64'h0000_0001_FFFF_FFFD);
    run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000);
    run_op("divu 5/0", 2'b11, 32'h0000_0005, 32'h0000_0000, 2, 64'h0000_0005_FFFF_FFFF);

    // Flush at N+10 of a DIV; the unit must be free at N+11.
    op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    seen_we = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      seen_we = seen_we | hl_write_enable;
    end
    check("flush busy before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    #1;
    seen_we = seen_we | hl_write_enable;
    tick();
    flush = 1'b0;
    check("flush no strobe", {63'd0, seen_we}, 64'd0);
    check("flush busy N+11", {63'd0, busy}, 64'd0);
    check("flush hl kept", hl_data, 64'h0000_0005_FFFF_FFFF);
    run_op("mult after flush", 2'b00, 32'd3, 32'd4, 2, 64'd12);

    // A start pulsed at N+5 during a DIVU must be ignored.
    op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    strobes = 0; first_cyc = 0; first_hl = 64'd0;
    for (int cyc = 2; cyc <= 40; cyc++) begin
      if (cyc == 6) begin
        start = 1'b0;
        src_a = 32'd100; src_b = 32'd7;
      end
      tick();
      if (cyc == 5) begin
        op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
      end
      if (hl_write_enable) begin
        strobes++;
        if (first_cyc == 0) begin
          first_cyc = cyc;
          first_hl = hl_data;
        end
      end
    end
    start = 1'b0;
    check("ignored start strobes", 64'(strobes), 64'd1);
    check("ignored start cycle", 64'(first_cyc), 64'd33);
    check("ignored start hl", first_hl, 64'h0000_0002_0000_000E);

    // Flush during DONE suppresses the strobe.
    op = 2'b00; src_a = 32'd2; src_b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("flush in done we", {63'd0, hl_write_enable}, 64'd0);
    tick();
    flush = 1'b0;
    check("flush in done idle", {63'd0, busy}, 64'd0);

    // Simultaneous flush and start in IDLE accepts nothing.
    op = 2'b00; src_a = 32'd5; src_b = 32'd5; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush+start idle", {63'd0, busy}, 64'd0);
    tick();

    // Reset at N+3 of a DIV clears everything at N+4 and no strobe follows.
    op = 2'b10; src_a = 32'd50; src_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst mid busy", {63'd0, busy}, 64'd0);
    check("rst mid we", {63'd0, hl_write_enable}, 64'd0);
    check("rst mid hl", hl_data, 64'd0);
    rst = 1'b0;
    seen_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen_we = seen_we | hl_write_enable;
    end
    check("rst no strobe", {63'd0, seen_we}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
